pc_fetch_sequencer: RTL and testbench

Program-counter and instruction-fetch sequencer for the RV64I SiMPLE core. It consumes the `pc_sel` code produced by the control-transfer unit, computes and registers the next PC, and runs the request/acknowledge fetch handshake with instruction memory. It presents the fetched instruction to decode and raises a one-cycle fault on misaligned control-transfer targets. The block sits between the control-transfer unit and the instruction memory port.

---
 rtl/riscv_pc_defs.sv | 18 +
 rtl/next_pc_logic.sv | 33 +++
 rtl/pc_fetch_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pc_defs.sv
// rtl/riscv_pc_defs.sv - shared next-PC select codes, fetch FSM states and NOP constant
package riscv_pc_defs;

  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JALR   = 2'b10;
  localparam logic [1:0] PC_SEL_TRAP   = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_TRAP  = 2'b11
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/next_pc_logic.sv
// rtl/next_pc_logic.sv - next-PC target mux, adders and alignment check
module next_pc_logic
  import riscv_pc_defs::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 64'h0000_0000_0000_0010
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_pc_sel,
  input  logic [XLEN-1:0] i_immediate,
  input  logic [XLEN-1:0] i_alu_result,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_target;

  always_comb begin
    w_target = i_pc + XLEN'(4);
    case (i_pc_sel)
      PC_SEL_PLUS4:  w_target = i_pc + XLEN'(4);
      PC_SEL_BRANCH: w_target = i_pc + i_immediate;
      PC_SEL_JALR:   w_target = i_alu_result & ~XLEN'(1);
      PC_SEL_TRAP:   w_target = TRAP_VECTOR;
      default:       w_target = i_pc + XLEN'(4);
    endcase
  end

  // Trap requests redirect to a fixed vector and never raise the alignment fault.
  assign o_next_pc    = w_target;
  assign o_misaligned = (i_pc_sel != PC_SEL_TRAP) && (w_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - PC register and instruction fetch handshake FSM
module pc_fetch_sequencer
  import riscv_pc_defs::*;
#(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0000_0000_0040_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 64'h0000_0000_0000_0010
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] alu_result,
  input  logic            retire,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus_4,
  output logic            misaligned_fault,
  output logic [XLEN-1:0] fault_addr
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus_4;
  logic [31:0]     r_inst;
  logic            r_inst_valid;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_addr;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;
  logic            w_fetch_done;
  logic            w_retire_take;

  next_pc_logic #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_pc (
    .i_pc         (r_pc),
    .i_pc_sel     (pc_sel),
    .i_immediate  (immediate),
    .i_alu_result (alu_result),
    .o_next_pc    (w_next_pc),
    .o_misaligned (w_misaligned)
  );

  assign w_fetch_done  = (r_state == ST_FETCH) && imem_ack;
  assign w_retire_take = (r_state == ST_EXEC) && retire;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT:  w_state_next = ST_FETCH;
      ST_FETCH: if (imem_ack) w_state_next = ST_EXEC;
      ST_EXEC: begin
        if (retire) begin
          if (pc_sel == PC_SEL_TRAP || w_misaligned) w_state_next = ST_TRAP;
          else                                       w_state_next = ST_FETCH;
        end
      end
      ST_TRAP:  w_state_next = ST_FETCH;
      default:  w_state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= RESET_VECTOR;
      r_pc_plus_4  <= RESET_VECTOR + XLEN'(4);
      r_inst       <= INST_NOP;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      r_fault <= 1'b0;
      if (w_fetch_done) begin
        r_inst       <= imem_rdata;
        r_inst_valid <= 1'b1;
      end
      if (w_retire_take) begin
        r_inst_valid <= 1'b0;
        if (pc_sel == PC_SEL_TRAP || w_misaligned) begin
          r_pc        <= TRAP_VECTOR;
          r_pc_plus_4 <= TRAP_VECTOR + XLEN'(4);
        end else begin
          r_pc        <= w_next_pc;
          r_pc_plus_4 <= w_next_pc + XLEN'(4);
        end
        // fault_addr keeps the last offending target until another fault replaces it
        if (w_misaligned) begin
          r_fault      <= 1'b1;
          r_fault_addr <= w_next_pc;
        end
      end
    end
  end

  assign imem_req         = (r_state == ST_FETCH);
  assign imem_addr        = r_pc;
  assign inst             = r_inst;
  assign inst_valid       = r_inst_valid;
  assign pc               = r_pc;
  assign pc_plus_4        = r_pc_plus_4;
  assign misaligned_fault = r_fault;
  assign fault_addr       = r_fault_addr;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic [1:0]  pc_sel;
  logic [63:0] immediate;
  logic [63:0] alu_result;
  logic        retire;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [63:0] pc;
  logic [63:0] pc_plus_4;
  logic        misaligned_fault;
  logic [63:0] fault_addr;

  int n_checks;
  int n_errors;

  pc_fetch_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .pc_sel           (pc_sel),
    .immediate        (immediate),
    .alu_result       (alu_result),
    .retire           (retire),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .inst             (inst),
    .inst_valid       (inst_valid),
    .pc               (pc),
    .pc_plus_4        (pc_plus_4),
    .misaligned_fault (misaligned_fault),
    .fault_addr       (fault_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // In FETCH: answer the pending request in the same cycle.
  task automatic fetch_now(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
  endtask

  // In EXEC: retire with the given selection.
  task automatic retire_now(input logic [1:0] sel, input logic [63:0] imm, input logic [63:0] alu);
    retire     = 1'b1;
    pc_sel     = sel;
    immediate  = imm;
    alu_result = alu;
    tick();
    retire     = 1'b0;
    pc_sel     = 2'b00;
    immediate  = '0;
    alu_result = '0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    pc_sel     = 2'b00;
    immediate  = '0;
    alu_result = '0;
    retire     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;

    tick();
    tick();
    check_eq("rst_req", 64'(imem_req), 64'd0);
    check_eq("rst_pc", pc, 64'h400000);
    check_eq("rst_pc4", pc_plus_4, 64'h400004);
    check_eq("rst_inst", 64'(inst), 64'h13);
    check_eq("rst_valid", 64'(inst_valid), 64'd0);
    check_eq("rst_fault", 64'(misaligned_fault), 64'd0);
    check_eq("rst_faddr", fault_addr, 64'd0);

    reset = 1'b0;
    check_eq("boot_req", 64'(imem_req), 64'd0);
    tick();
    check_eq("fetch0_req", 64'(imem_req), 64'd1);
    check_eq("fetch0_addr", imem_addr, 64'h400000);
    fetch_now(32'h00500093);
    check_eq("exec0_inst", 64'(inst), 64'h00500093);
    check_eq("exec0_valid", 64'(inst_valid), 64'd1);
    check_eq("exec0_req", 64'(imem_req), 64'd0);

    // stray ack during EXEC must not overwrite the instruction
    imem_ack = 1'b1;
    imem_rdata = 32'h11111111;
    tick();
    imem_ack = 1'b0;
    check_eq("exec_stray_ack", 64'(inst), 64'h00500093);

    // three sequential retires, 2 cycles per instruction
    retire_now(2'b00, '0, '0);
    check_eq("seq1_req", 64'(imem_req), 64'd1);
    check_eq("seq1_addr", imem_addr, 64'h400004);
    check_eq("seq1_valid", 64'(inst_valid), 64'd0);
    fetch_now(32'h00000013);
    retire_now(2'b00, '0, '0);
    check_eq("seq2_addr", imem_addr, 64'h400008);
    check_eq("seq2_pc4", pc_plus_4, 64'h40000C);
    fetch_now(32'h00000013);
    retire_now(2'b00, '0, '0);
    check_eq("seq3_req", 64'(imem_req), 64'd1);
    check_eq("seq3_addr", imem_addr, 64'h40000C);

    // JAL back to 0x400008, then branch -8 to 0x400000
    fetch_now(32'h00000013);
    retire_now(2'b01, 64'hFFFF_FFFF_FFFF_FFFC, '0);
    check_eq("jal_addr", imem_addr, 64'h400008);
    fetch_now(32'h00000013);
    retire_now(2'b01, 64'hFFFF_FFFF_FFFF_FFF8, '0);
    check_eq("br_neg_addr", imem_addr, 64'h400000);
    check_eq("br_neg_fault", 64'(misaligned_fault), 64'd0);

    // jump to top of address space, then wrap with +8
    fetch_now(32'h00000013);
    retire_now(2'b01, 64'hFFFF_FFFF_FFBF_FFFC, '0);
    check_eq("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("top_pc4", pc_plus_4, 64'h0);
    fetch_now(32'h00000013);
    retire_now(2'b01, 64'd8, '0);
    check_eq("wrap_addr", imem_addr, 64'h4);
    check_eq("wrap_fault", 64'(misaligned_fault), 64'd0);

    // JALR with odd target: bit 0 cleared, no fault
    fetch_now(32'h00000013);
    retire_now(2'b10, '0, 64'h400101);
    check_eq("jalr_addr", imem_addr, 64'h400100);
    check_eq("jalr_fault", 64'(misaligned_fault), 64'd0);
    check_eq("jalr_req", 64'(imem_req), 64'd1);

    // three wait states with a stray retire in the middle
    for (int i = 0; i < 3; i++) begin
      retire = (i == 1);
      pc_sel = 2'b01;
      immediate = 64'h40;
      tick();
      check_eq("wait_addr", imem_addr, 64'h400100);
      check_eq("wait_valid", 64'(inst_valid), 64'd0);
      check_eq("wait_req", 64'(imem_req), 64'd1);
    end
    retire = 1'b0;
    pc_sel = 2'b00;
    immediate = '0;
    check_eq("wait_pc", pc, 64'h400100);
    fetch_now(32'h000080E7);
    check_eq("wait_inst", 64'(inst), 64'h000080E7);
    check_eq("wait_valid_up", 64'(inst_valid), 64'd1);

    // JALR to 0x400102: fault pulse, TRAP bubble, fetch at TRAP_VECTOR
    retire_now(2'b10, '0, 64'h400102);
    check_eq("jfault_pulse", 64'(misaligned_fault), 64'd1);
    check_eq("jfault_addr", fault_addr, 64'h400102);
    check_eq("jfault_req", 64'(imem_req), 64'd0);
    check_eq("jfault_pc", pc, 64'h10);
    tick();
    check_eq("jfault_clear", 64'(misaligned_fault), 64'd0);
    check_eq("jfault_hold", fault_addr, 64'h400102);
    check_eq("trap_fetch_req", 64'(imem_req), 64'd1);
    check_eq("trap_fetch_addr", imem_addr, 64'h10);

    // misaligned branch target 0x16
    fetch_now(32'h00000013);
    retire_now(2'b01, 64'd6, '0);
    check_eq("bfault_pulse", 64'(misaligned_fault), 64'd1);
    check_eq("bfault_addr", fault_addr, 64'h16);
    tick();
    check_eq("bfault_addr_fetch", imem_addr, 64'h10);

    // trap request: redirect without fault flag
    fetch_now(32'h00000073);
    retire_now(2'b11, '0, '0);
    check_eq("trap_pc", pc, 64'h10);
    check_eq("trap_nofault", 64'(misaligned_fault), 64'd0);
    check_eq("trap_bubble_req", 64'(imem_req), 64'd0);
    check_eq("trap_faddr_keep", fault_addr, 64'h16);
    tick();
    check_eq("trap_refetch", 64'(imem_req), 64'd1);

    // reset during FETCH with same-cycle ack, then a late ack in BOOT
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    tick();
    reset = 1'b0;
    check_eq("mrst_inst", 64'(inst), 64'h13);
    check_eq("mrst_valid", 64'(inst_valid), 64'd0);
    check_eq("mrst_pc", pc, 64'h400000);
    check_eq("mrst_req", 64'(imem_req), 64'd0);
    check_eq("mrst_faddr", fault_addr, 64'd0);
    tick();
    imem_ack = 1'b0;
    check_eq("late_ack_inst", 64'(inst), 64'h13);
    check_eq("late_ack_req", 64'(imem_req), 64'd1);
    check_eq("late_ack_addr", imem_addr, 64'h400000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
